// File: rtl/to_twos_complement_serial_pkg.sv
// Shared calculator-datapath definitions: converter FSM encoding and default magnitude width.
package to_twos_complement_serial_pkg;

    localparam int DEFAULT_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/to_twos_complement_serial_twos_bit_slice.sv
// One bit of serial negation: pass bits up to and including the first 1, invert the rest.
module twos_bit_slice (
    input  logic b,
    input  logic sign_q,
    input  logic seen_one,
    output logic o,
    output logic seen_one_next
);

    assign o             = (sign_q && seen_one) ? ~b : b;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/to_twos_complement_serial.sv
// Bit-serial sign-magnitude to (bits+1)-bit two's complement converter, LSB first.
// Latency: bits cycles from accept to out_valid; result held stable while out_ready is low.
module to_twos_complement_serial
    import to_twos_complement_serial_pkg::*;
#(
    parameter int bits = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sign,
    input  logic [bits-1:0] value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [bits:0]   twos_comp,
    output logic            neg_zero
);

    localparam int              CNT_W    = $clog2(bits);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(bits - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [bits-1:0]   mag_sr;
    logic [bits-1:0]   res_sr;
    logic              sign_q;
    logic              seen_one;
    logic              o;
    logic              seen_one_next;
    logic              accept;
    logic              last_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_bit  = (state == SHIFT) && (cnt == CNT_LAST);

    twos_bit_slice u_slice (
        .b             (mag_sr[0]),
        .sign_q        (sign_q),
        .seen_one      (seen_one),
        .o             (o),
        .seen_one_next (seen_one_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mag_sr    <= '0;
            res_sr    <= '0;
            sign_q    <= 1'b0;
            seen_one  <= 1'b0;
            twos_comp <= '0;
            neg_zero  <= 1'b0;
        end else if (accept) begin
            mag_sr   <= value;
            sign_q   <= sign;
            seen_one <= 1'b0;
            cnt      <= '0;
            res_sr   <= '0;
        end else if (state == SHIFT) begin
            seen_one <= seen_one_next;
            mag_sr   <= mag_sr >> 1;
            res_sr   <= {o, res_sr[bits-1:1]};
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                // Capture from the post-shift view so the final bit is included.
                twos_comp <= {sign_q && seen_one_next, o, res_sr[bits-1:1]};
                neg_zero  <= sign_q && !seen_one_next;
            end
        end
    end

endmodule

// File: doc/to_twos_complement_serial.md
# to_twos_complement_serial

Bit-serial converter from sign-magnitude to (bits+1)-bit two's complement, the inverse of the datapath's two's-complement-to-sign-magnitude conversion. It sits between the operand-entry/display side of the calculator datapath, where values are held as sign plus magnitude, and the arithmetic core, which consumes two's complement. It processes one magnitude bit per clock, LSB first, behind valid/ready handshakes on both sides, so the logic is one bit-slice plus a counter rather than a full-width incrementer.

## Interface
- bits, 8: magnitude width; legal range ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sign/value present and stable.
- in_ready  output  1  block accepts a new operand this cycle.
- sign  input  1  1 = negative.
- value  input  bits  magnitude, unsigned.
- out_valid  output  1  twos_comp holds a finished result.
- out_ready  input  1  downstream consumes the result this cycle.
- twos_comp  output  bits+1  two's-complement result; MSB is the sign bit.
- neg_zero  output  1  qualifies twos_comp: the accepted operand was sign=1, value=0.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on in_valid && in_ready.
  - SHIFT → DONE when the bit counter reaches bits-1, i.e. after exactly bits SHIFT cycles.
  - DONE → IDLE on out_ready.
- Handshake outputs are decoded from the state: in_ready = (state == IDLE); out_valid = (state == DONE).
- On accept:
  - Register value into mag_sr and sign into sign_q.
  - Clear seen_one and the counter.
  - Clear the result shift register.
- Each SHIFT cycle, with b = mag_sr[0]:
  - Output bit o = sign_q && seen_one ? ~b : b.
  - seen_one ← seen_one | b.
  - mag_sr shifts right one place.
  - res_sr shifts right one place, with o inserted at bit bits-1.
- Entering DONE:
  - twos_comp ← {sign_q && seen_one, res_sr}.
  - neg_zero ← sign_q && !seen_one.
- Arithmetic: the result equals the sign-magnitude value exactly.
  - The full magnitude range 0..2^bits−1 is representable; −(2^bits−1) maps to 1 followed by (bits−1) zeros and a final 1, with no overflow.
  - Negative zero yields an all-zero result with the sign bit 0. neg_zero is the only trace of the input sign.
- Counter width: $clog2(bits). The counter must not wrap inside a conversion.
- Inputs are sampled only on the accept edge. Changes to sign/value during SHIFT or DONE have no effect.

## Timing
- Reset values (asserted asynchronously, released synchronously to clk):
  - state = IDLE, so in_ready = 1 and out_valid = 0.
  - twos_comp = 0, neg_zero = 0.
  - All internal registers = 0.
- Latency: acceptance at edge N → out_valid = 1 after edge N+bits, i.e. bits cycles.
- Throughput: one operand per bits+2 cycles with out_ready held high.
  - Pattern: accept edge, bits SHIFT edges, DONE→IDLE edge.
  - in_ready is 0 from the accept edge until the DONE→IDLE edge.
- Backpressure: while out_valid && !out_ready, twos_comp and neg_zero stay stable for any number of cycles.
- out_ready while not in DONE is ignored.
- in_valid while not in IDLE is ignored; no operand is lost, because the source holds in_valid until in_ready.
- twos_comp and neg_zero are registered. Outside DONE they keep their last value but are meaningful only when out_valid = 1.
- Reset mid-SHIFT or mid-DONE:
  - The conversion is abandoned and nothing is produced.
  - The first in_ready after reset release occurs in the same cycle.

## Structure
- Shared datapath package holds:
  - FSM state encoding (IDLE, SHIFT, DONE; 2-bit).
  - The default bits value (8), shared with the two's-complement-to-sign-magnitude converter.
- Natural sub-module: twos_bit_slice, a combinational cell taking (b, sign_q, seen_one) and producing (o, seen_one_next). Reusable for a future serial negator.
- Control (FSM plus counter) and datapath (mag_sr, res_sr, seen_one) stay in the top module.

## Test plan
All scenarios use bits = 8.
- sign=0, value=5 → twos_comp = 0_0000_0101, neg_zero = 0, out_valid exactly 8 cycles after accept.
- sign=1, value=5 → 1_1111_1011; sign=1, value=255 → 1_0000_0001; sign=0, value=255 → 0_1111_1111.
- sign=1, value=0 → twos_comp = 0_0000_0000, neg_zero = 1.
- Backpressure:
  - Stimulus: result for −128, out_ready low 3 cycles after out_valid, then high.
  - Response: 1_1000_0000 stable all 4 cycles, in_ready = 0 until the cycle after the handshake.
  - Stimulus: change value and sign during SHIFT. Response: result unaffected.
- Reset mid-conversion:
  - Stimulus: rst_n low at the 4th SHIFT cycle of −37.
  - Response: out_valid never rises, outputs zero, in_ready = 1 immediately.
  - Then +37 converts correctly to 0_0010_0101.
- Random back-to-back: 1000 random operands with random in_valid/out_ready gaps → every result matches the reference model, in order, with none dropped or duplicated.
